// File: rtl/ifu_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ifu_fetch : multicycle single-issue instruction fetch (imem AR/R -> decode)
// Revision  : 1.0
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_araddr,
  output logic            imem_arvalid,
  input  logic            imem_arready,
  input  logic [31:0]     imem_rdata,
  input  logic [1:0]      imem_rresp,
  input  logic            imem_rvalid,
  output logic            imem_rready,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  output logic            inst_misalign,
  input  logic            next_pc_valid,
  input  logic [XLEN-1:0] next_pc,
  output logic            next_pc_ready
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_NEXT = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            rsp_err;

  assign rsp_err = (imem_rresp != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_BOOT;
      pc            <= RESET_PC;
      imem_araddr   <= RESET_PC;
      imem_arvalid  <= 1'b0;
      imem_rready   <= 1'b0;
      inst_valid    <= 1'b0;
      inst          <= '0;
      inst_pc       <= '0;
      inst_fault    <= 1'b0;
      inst_misalign <= 1'b0;
      next_pc_ready <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          imem_arvalid <= 1'b1;
          imem_araddr  <= pc;
          state        <= S_REQ;
        end
        S_REQ: begin
          if (imem_arready) begin
            imem_arvalid <= 1'b0;
            imem_rready  <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            imem_rready <= 1'b0;
            inst_fault  <= rsp_err;
            inst        <= rsp_err ? 32'h0 : imem_rdata;
            inst_pc     <= pc;
            inst_valid  <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid    <= 1'b0;
            next_pc_ready <= 1'b1;
            state         <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (next_pc_valid) begin
            next_pc_ready <= 1'b0;
            pc            <= next_pc;
            inst_fault    <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              inst_misalign <= 1'b0;
              imem_arvalid  <= 1'b1;
              imem_araddr   <= next_pc;
              state         <= S_REQ;
            end else begin
              // Misaligned target never reaches the bus; report it straight to decode.
              inst_misalign <= 1'b1;
              inst          <= 32'h0;
              inst_pc       <= next_pc;
              inst_valid    <= 1'b1;
              state         <= S_OUT;
            end
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  a_ar_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    imem_arvalid |-> !(imem_rready || inst_valid || next_pc_ready));
  a_ar_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_arvalid && !imem_arready) |=> (imem_arvalid && $stable(imem_araddr)));
  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (inst_valid && !inst_ready) |=> (inst_valid && $stable(inst) && $stable(inst_pc)));
  a_valid_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_valid && next_pc_ready));

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ifu_fetch : randomized scoreboard bench for ifu_fetch
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_araddr;
  logic        imem_arvalid;
  logic        imem_arready;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rvalid;
  logic        imem_rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_misalign;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        next_pc_ready;

  always #5 clk = ~clk;

  ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_araddr(imem_araddr), .imem_arvalid(imem_arvalid), .imem_arready(imem_arready),
    .imem_rdata(imem_rdata), .imem_rresp(imem_rresp), .imem_rvalid(imem_rvalid),
    .imem_rready(imem_rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .inst_misalign(inst_misalign),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc), .next_pc_ready(next_pc_ready)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        f;
    logic        m;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          passes = 0;
  int          out_count = 0;

  // Memory contents and error map of the imaginary instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[6:2] == 5'd3);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: actual timeout required completion", name);
  endtask

  // Reference model: what decode must see for a fetch of pc.
  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.m    = (pc[1:0] != 2'b00);
    e.f    = !e.m && bad_addr(pc);
    e.inst = (e.m || e.f) ? 32'h0 : mem_word(pc);
    exp_q.push_back(e);
    if (!e.m) addr_q.push_back(pc);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_araddr"},  128'(imem_araddr),  128'(RESET_PC));
    chk({tag, "_arvalid"}, 128'(imem_arvalid), 128'(0));
    chk({tag, "_rready"},  128'(imem_rready),  128'(0));
    chk({tag, "_ivalid"},  128'(inst_valid),   128'(0));
    chk({tag, "_inst"},    128'(inst),         128'(0));
    chk({tag, "_inst_pc"}, 128'(inst_pc),      128'(0));
    chk({tag, "_flags"},   128'({inst_fault, inst_misalign}), 128'(0));
    chk({tag, "_npready"}, 128'(next_pc_ready), 128'(0));
  endtask

  task automatic wait_outputs(input int n);
    int i;
    for (i = 0; i < 3000 && out_count < n; i++) @(posedge clk);
    if (out_count < n) fail_now("wait_outputs");
  endtask

  // Instruction memory responder.
  initial begin
    int ac, ad, rc, rd, txn;
    logic busy, arhs, rhs;
    logic [31:0] addr;
    imem_arready = 0; imem_rvalid = 0; imem_rdata = 0; imem_rresp = 0;
    ac = 0; ad = 0; rc = 0; rd = 0; txn = 0; busy = 0; arhs = 0; rhs = 0; addr = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        imem_arready = 0; imem_rvalid = 0;
        busy = 0; arhs = 0; rhs = 0; ac = 0; ad = 0; rc = 0;
        continue;
      end
      imem_arready = 0; imem_rvalid = 0; imem_rresp = 0; imem_rdata = $urandom;
      if (rhs) begin rhs = 0; busy = 0; end
      if (arhs) begin arhs = 0; busy = 1; rc = 0; end
      if (!busy && imem_arvalid) begin
        if (ac >= ad) begin
          imem_arready = 1; arhs = 1; addr = imem_araddr; ac = 0;
          if (addr_q.size() == 0) begin
            checks++;
            $display("FAIL ar_addr: actual %h required no request", addr);
          end else chk("ar_addr", 128'(addr), 128'(addr_q.pop_front()));
          rd  = (txn == 0) ? 0 : $urandom_range(0, 2);
          txn++;
          ad  = (txn == 1) ? 5 : $urandom_range(0, 3);
        end else ac++;
      end else if (busy && imem_rready) begin
        if (rc >= rd) begin
          imem_rvalid = 1; rhs = 1;
          imem_rdata  = mem_word(addr);
          imem_rresp  = bad_addr(addr) ? 2'($urandom_range(1, 3)) : 2'b00;
        end else rc++;
      end else begin
        imem_arready = 1'($urandom_range(0, 1));
        imem_rvalid  = 1'($urandom_range(0, 1));
        imem_rresp   = 2'($urandom_range(0, 3));
      end
    end
  end

  // Commit stage: supplies the next PC.
  initial begin
    int cnt, dly, idx, r;
    logic drv;
    logic [31:0] cur, nxt;
    next_pc_valid = 0; next_pc = 0;
    cnt = 0; dly = 0; idx = 0; drv = 0; cur = RESET_PC; nxt = 0; r = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        next_pc_valid = 0; cur = RESET_PC; cnt = 0; drv = 0;
        continue;
      end
      if (drv) begin drv = 0; cnt = 0; dly = $urandom_range(0, 3); end
      if (next_pc_ready) begin
        if (cnt >= dly) begin
          case (idx)
            0: nxt = 32'h8000_000C;
            1: nxt = 32'h8000_0004;
            2: nxt = 32'h8000_0006;
            3: nxt = 32'h8000_0008;
            default: begin
              r = $urandom_range(0, 9);
              if (r < 6)      nxt = cur + 32'd4;
              else if (r < 8) nxt = RESET_PC | ($urandom & 32'h0000_0FFC);
              else            nxt = RESET_PC | ($urandom & 32'h0000_0FFF) | 32'h1;
            end
          endcase
          next_pc_valid = 1; next_pc = nxt;
          push_exp(nxt);
          cur = nxt; drv = 1; idx++;
        end else begin
          next_pc_valid = 0; cnt++;
        end
      end else begin
        next_pc_valid = 1'($urandom_range(0, 1));
        next_pc       = $urandom;
      end
    end
  end

  // Decode stage: accepts instructions after a variable stall.
  initial begin
    int cnt, dly, idx;
    logic active;
    inst_ready = 0; cnt = 0; dly = 0; idx = 0; active = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin inst_ready = 0; cnt = 0; active = 0; continue; end
      if (inst_valid) begin
        if (!active) begin
          active = 1; cnt = 0;
          dly = (idx == 0) ? 0 : (idx == 1) ? 4 : $urandom_range(0, 3);
        end
        if (cnt >= dly) begin inst_ready = 1; active = 0; idx++; end
        else begin inst_ready = 0; cnt++; end
      end else begin
        inst_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: protocol checks and scoreboard pop.
  initial begin
    logic pv_iv, pv_ir, pv_av, pv_ar, pv_f, pv_m;
    logic [31:0] pv_inst, pv_ipc, pv_addr;
    exp_t e;
    pv_iv = 0; pv_ir = 0; pv_av = 0; pv_ar = 0; pv_f = 0; pv_m = 0;
    pv_inst = 0; pv_ipc = 0; pv_addr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pv_iv = 0; pv_ir = 0; pv_av = 0; pv_ar = 0; continue; end
      if (pv_av && !pv_ar)
        chk("ar_hold", 128'({imem_arvalid, imem_araddr}), 128'({1'b1, pv_addr}));
      if (pv_iv && !pv_ir)
        chk("inst_hold", 128'({inst_valid, inst, inst_pc, inst_fault, inst_misalign}),
            128'({1'b1, pv_inst, pv_ipc, pv_f, pv_m}));
      if (pv_iv && pv_ir)
        chk("npready_after_out", 128'({inst_valid, next_pc_ready}), 128'(2'b01));
      if (inst_valid || next_pc_ready)
        chk("valid_ready_excl", 128'(inst_valid & next_pc_ready), 128'(0));
      if (imem_arvalid)
        chk("ar_only_in_req", 128'({imem_rready, inst_valid, next_pc_ready}), 128'(0));
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL inst_out: actual pc %h required no output", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_out", 128'({inst, inst_pc, inst_fault, inst_misalign}), 128'(e));
        end
        out_count++;
      end
      pv_iv = inst_valid; pv_ir = inst_ready; pv_av = imem_arvalid; pv_ar = imem_arready;
      pv_inst = inst; pv_ipc = inst_pc; pv_f = inst_fault; pv_m = inst_misalign;
      pv_addr = imem_araddr;
    end
  end

  initial begin
    bit found;
    rst_n = 1;
    #3 rst_n = 0;
    #1 reset_checks("rst_async");
    repeat (3) @(posedge clk);
    #1 reset_checks("rst_hold");
    push_exp(RESET_PC);
    @(negedge clk);
    rst_n = 1;
    wait_outputs(40);

    // Pull reset while a read response is being presented in WAIT.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_rready && imem_rvalid) found = 1;
    end
    if (!found) fail_now("find_wait");
    else begin
      rst_n = 0;
      #1 reset_checks("rst_mid");
      exp_q.delete();
      addr_q.delete();
      push_exp(RESET_PC);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      wait_outputs(out_count + 10);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
